// File: rtl/gshare_fetch_ctrl.sv
// gshare front-end control: PHT index formation, speculative GHR,
// in-flight branch FIFO, commit-time PHT update and mispredict repair.
module gshare_fetch_ctrl #(
    parameter int I_WIDTH = 7,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [31:0]        fetchPC,
    input  logic               branchFetch,
    output logic [I_WIDTH:0]   index,
    input  logic [1:0]         gshareState,
    output logic               predValid,
    output logic               predTaken,
    output logic               fetchStall,
    input  logic               commitValid,
    input  logic               commitTaken,
    input  logic               mispredict,
    output logic [I_WIDTH:0]   previousIndex,
    output logic [1:0]         newState,
    output logic               predictorWrite
);

    localparam int IW = I_WIDTH + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IW-1:0] ghr;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] last;
    logic [CW-1:0] count;
    logic          pending;

    logic [IW-1:0] idx_q [DEPTH];
    logic [IW-1:0] ghr_q [DEPTH];
    logic [1:0]    st_q  [DEPTH];

    logic          do_commit;
    logic          flush;
    logic          accept;
    logic          bypass;
    logic [1:0]    head_st;
    logic [1:0]    upd_st;

    logic          unused_pc;
    assign unused_pc = ^{fetchPC[31:I_WIDTH+3], fetchPC[1:0]};

    assign index      = fetchPC[I_WIDTH+2:2] ^ ghr;
    assign fetchStall = (count == CW'(DEPTH));
    assign predValid  = pending;
    assign predTaken  = pending & gshareState[1];

    assign do_commit = commitValid && (count != '0);
    assign flush     = do_commit && mispredict;
    assign accept    = branchFetch && !fetchStall && !flush;

    // Head is the entry whose state is only arriving this cycle.
    assign bypass  = pending && (count == CW'(1));
    assign head_st = bypass ? gshareState : st_q[head];

    always_comb begin
        upd_st = head_st;
        if (commitTaken) begin
            if (head_st != 2'b11) upd_st = head_st + 2'd1;
        end else begin
            if (head_st != 2'b00) upd_st = head_st - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ghr            <= '0;
            head           <= '0;
            tail           <= '0;
            last           <= '0;
            count          <= '0;
            pending        <= 1'b0;
            previousIndex  <= '0;
            newState       <= 2'b00;
            predictorWrite <= 1'b0;
        end else begin
            predictorWrite <= do_commit;
            if (do_commit) begin
                previousIndex <= idx_q[head];
                newState      <= upd_st;
            end
            if (flush) begin
                ghr     <= {ghr_q[head][IW-2:0], commitTaken};
                head    <= tail;
                count   <= '0;
                pending <= 1'b0;
            end else begin
                if (pending) ghr <= {ghr[IW-2:0], gshareState[1]};
                if (do_commit) head <= head + PW'(1);
                if (accept) begin
                    tail <= tail + PW'(1);
                    last <= tail;
                end
                count   <= count + CW'(accept) - CW'(do_commit);
                pending <= accept;
            end
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q[tail] <= index;
            ghr_q[tail] <= ghr;
            st_q[tail]  <= 2'b00;
        end
        if (pending && !flush) st_q[last] <= gshareState;
    end

endmodule

// File: tb/tb_gshare_fetch_ctrl.sv
// Directed bench for gshare_fetch_ctrl: vector table plus
// sequences for full FIFO, async reset, overlap and mispredict.
module tb_gshare_fetch_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic [31:0] fetchPC;
    logic        branchFetch;
    logic [7:0]  index;
    logic [1:0]  gshareState;
    logic        predValid;
    logic        predTaken;
    logic        fetchStall;
    logic        commitValid;
    logic        commitTaken;
    logic        mispredict;
    logic [7:0]  previousIndex;
    logic [1:0]  newState;
    logic        predictorWrite;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gshare_fetch_ctrl #(.I_WIDTH(7), .DEPTH(8)) dut (
        .clk(clk),
        .resetN(resetN),
        .fetchPC(fetchPC),
        .branchFetch(branchFetch),
        .index(index),
        .gshareState(gshareState),
        .predValid(predValid),
        .predTaken(predTaken),
        .fetchStall(fetchStall),
        .commitValid(commitValid),
        .commitTaken(commitTaken),
        .mispredict(mispredict),
        .previousIndex(previousIndex),
        .newState(newState),
        .predictorWrite(predictorWrite)
    );

    typedef struct {
        logic [31:0] pc;
        logic        bf;
        logic [1:0]  gs;
        logic        cv;
        logic        ct;
        logic        mp;
        logic [7:0]  e_idx;
        logic        e_pv;
        logic        e_pt;
        logic        e_st;
        logic        e_pw;
        logic [7:0]  e_pi;
        logic [1:0]  e_ns;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic bf,
                         input logic [1:0] gs, input logic cv,
                         input logic ct, input logic mp);
        fetchPC     = pc;
        branchFetch = bf;
        gshareState = gs;
        commitValid = cv;
        commitTaken = ct;
        mispredict  = mp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        drive(32'h0, 0, 2'b00, 0, 0, 0);
        tick();
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{32'h040, 1, 2'd0, 0, 0, 0, 8'h10, 0, 0, 0, 0, 8'h00, 2'd0};
        tbl[1]  = '{32'h040, 0, 2'd2, 0, 0, 0, 8'h10, 1, 1, 0, 0, 8'h00, 2'd0};
        tbl[2]  = '{32'h040, 0, 2'd0, 1, 1, 0, 8'h11, 0, 0, 0, 0, 8'h00, 2'd0};
        tbl[3]  = '{32'h080, 1, 2'd0, 0, 0, 0, 8'h21, 0, 0, 0, 1, 8'h10, 2'd3};
        tbl[4]  = '{32'h000, 0, 2'd3, 0, 0, 0, 8'h01, 1, 1, 0, 0, 8'h10, 2'd3};
        tbl[5]  = '{32'h000, 0, 2'd0, 1, 1, 0, 8'h03, 0, 0, 0, 0, 8'h10, 2'd3};
        tbl[6]  = '{32'h000, 1, 2'd0, 0, 0, 0, 8'h03, 0, 0, 0, 1, 8'h21, 2'd3};
        tbl[7]  = '{32'h000, 0, 2'd0, 0, 0, 0, 8'h03, 1, 0, 0, 0, 8'h21, 2'd3};
        tbl[8]  = '{32'h000, 0, 2'd0, 1, 0, 0, 8'h06, 0, 0, 0, 0, 8'h21, 2'd3};
        tbl[9]  = '{32'h3fc, 1, 2'd0, 0, 0, 0, 8'hf9, 0, 0, 0, 1, 8'h03, 2'd0};
        tbl[10] = '{32'h000, 0, 2'd1, 0, 0, 0, 8'h06, 1, 0, 0, 0, 8'h03, 2'd0};
        tbl[11] = '{32'h000, 0, 2'd0, 1, 1, 0, 8'h0c, 0, 0, 0, 0, 8'h03, 2'd0};
        tbl[12] = '{32'h000, 0, 2'd0, 0, 0, 0, 8'h0c, 0, 0, 0, 1, 8'hf9, 2'd2};
        tbl[13] = '{32'h000, 0, 2'd0, 1, 0, 0, 8'h0c, 0, 0, 0, 0, 8'hf9, 2'd2};
        tbl[14] = '{32'h000, 0, 2'd0, 0, 0, 0, 8'h0c, 0, 0, 0, 0, 8'hf9, 2'd2};
        tbl[15] = '{32'h040, 1, 2'd0, 0, 0, 0, 8'h1c, 0, 0, 0, 0, 8'hf9, 2'd2};
        tbl[16] = '{32'h000, 0, 2'd3, 1, 0, 0, 8'h0c, 1, 1, 0, 0, 8'hf9, 2'd2};
        tbl[17] = '{32'h000, 0, 2'd0, 0, 0, 0, 8'h19, 0, 0, 0, 1, 8'h1c, 2'd2};

        resetN = 1'b0;
        drive(32'h0, 0, 2'b00, 0, 0, 0);
        tick();
        #2;
        chk("rst pv", predValid, 0);
        chk("rst stall", fetchStall, 0);
        chk("rst pw", predictorWrite, 0);
        chk("rst pi", previousIndex, 0);
        chk("rst ns", newState, 0);
        chk("rst idx", index, 0);
        tick();
        resetN = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].pc, tbl[i].bf, tbl[i].gs,
                  tbl[i].cv, tbl[i].ct, tbl[i].mp);
            #2;
            chk($sformatf("r%0d idx", i), index, tbl[i].e_idx);
            chk($sformatf("r%0d pv", i), predValid, tbl[i].e_pv);
            chk($sformatf("r%0d pt", i), predTaken, tbl[i].e_pt);
            chk($sformatf("r%0d stall", i), fetchStall, tbl[i].e_st);
            chk($sformatf("r%0d pw", i), predictorWrite, tbl[i].e_pw);
            chk($sformatf("r%0d pi", i), previousIndex, tbl[i].e_pi);
            chk($sformatf("r%0d ns", i), newState, tbl[i].e_ns);
            tick();
        end

        // Full FIFO: eight fetches, ninth ignored, one commit unstalls.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(32'h100 + 32'(4 * i), 1, 2'b00, 0, 0, 0);
            #2;
            chk("full nostall", fetchStall, 0);
            tick();
        end
        drive(32'h200, 1, 2'b00, 0, 0, 0);
        #2;
        chk("full stall", fetchStall, 1);
        tick();
        drive(32'h0, 0, 2'b00, 1, 1, 0);
        #2;
        chk("full count", dut.count, 8);
        chk("full stall2", fetchStall, 1);
        tick();
        drive(32'h0, 0, 2'b00, 0, 0, 0);
        #2;
        chk("unfull stall", fetchStall, 0);
        chk("unfull count", dut.count, 7);
        chk("unfull pw", predictorWrite, 1);
        chk("unfull pi", previousIndex, 8'h40);
        chk("unfull ns", newState, 2'd1);

        // Asynchronous reset mid-operation.
        #1;
        resetN = 1'b0;
        #1;
        chk("areset pw", predictorWrite, 0);
        chk("areset count", dut.count, 0);
        chk("areset stall", fetchStall, 0);
        chk("areset pi", previousIndex, 0);
        tick();
        resetN = 1'b1;

        // Three branches building GHR=0x05, then overlapped fetch+commit.
        drive(32'h04, 1, 2'b00, 0, 0, 0);
        #2; chk("s1 idx", index, 8'h01); tick();
        drive(32'h08, 1, 2'b10, 0, 0, 0);
        #2; chk("s2 idx", index, 8'h02); chk("s2 pt", predTaken, 1); tick();
        drive(32'h10, 1, 2'b00, 0, 0, 0);
        #2; chk("s3 idx", index, 8'h05); chk("s3 pt", predTaken, 0); tick();
        drive(32'h00, 0, 2'b10, 0, 0, 0);
        #2; chk("s4 idx", index, 8'h02); chk("s4 pv", predValid, 1); tick();
        drive(32'h20, 1, 2'b00, 1, 1, 0);
        #2; chk("s5 idx", index, 8'h0d); chk("s5 count", dut.count, 3); tick();
        drive(32'h00, 0, 2'b10, 0, 0, 0);
        #2;
        chk("s6 count", dut.count, 3);
        chk("s6 pw", predictorWrite, 1);
        chk("s6 pi", previousIndex, 8'h01);
        chk("s6 ns", newState, 2'd3);
        chk("s6 pt", predTaken, 1);
        tick();
        drive(32'h00, 0, 2'b00, 1, 0, 0);
        #2; chk("s7 idx", index, 8'h0b); tick();
        drive(32'h40, 1, 2'b00, 1, 1, 0);
        #2;
        chk("s8 pi", previousIndex, 8'h02);
        chk("s8 ns", newState, 2'd0);
        chk("s8 idx", index, 8'h1b);
        tick();
        // Mispredict of A (snapshot 0x05) while B is in flight.
        drive(32'h80, 1, 2'b00, 1, 0, 1);
        #2;
        chk("s9 pi", previousIndex, 8'h05);
        chk("s9 ns", newState, 2'd3);
        chk("s9 pv", predValid, 1);
        chk("s9 pt", predTaken, 0);
        tick();
        drive(32'h00, 0, 2'b00, 1, 0, 0);
        #2;
        chk("mp pw", predictorWrite, 1);
        chk("mp pi", previousIndex, 8'h0d);
        chk("mp ns", newState, 2'd1);
        chk("mp ghr", index, 8'h0a);
        chk("mp count", dut.count, 0);
        chk("mp pv", predValid, 0);
        tick();
        drive(32'h00, 0, 2'b00, 0, 0, 0);
        #2;
        chk("empty pw", predictorWrite, 0);
        chk("empty head", dut.head, 5);
        chk("empty tail", dut.tail, 5);
        chk("empty count", dut.count, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
